// File: rtl/feature_map_pkg.sv
// Shared types and helpers for the feature-map browser and the conv engine write side.
// Holds the FSM state enum, cursor struct, width helper and flat address function.
package feature_map_pkg;

  // Wide enough for any practical map dimension. Callers slice down to their own widths.
  localparam int unsigned IDX_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_NEXT,
    OP_PREV,
    OP_CH_NEXT,
    OP_CH_PREV
  } move_op_t;

  typedef struct packed {
    logic [IDX_W-1:0] ch;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
  } cursor_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned flat_addr(input cursor_t c, input int unsigned height,
                                            input int unsigned width);
    return 32'(c.ch) * height * width + 32'(c.row) * width + 32'(c.col);
  endfunction

endpackage

// File: rtl/feature_map_browser_mixed_radix_counter.sv
// Combinational (ch,row,col) stepper: col-fastest carry/borrow and channel moves.
// End-of-map moves saturate, or wrap when FEATURE_MAP_BROWSER_WRAP_EN is defined.
module mixed_radix_counter
  import feature_map_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned HEIGHT   = 4,
  parameter int unsigned WIDTH    = 4
) (
  input  cursor_t  cur,
  input  move_op_t op,
  output cursor_t  nxt,
  output logic     moved
);

`ifdef FEATURE_MAP_BROWSER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(CHANNELS - 1);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(HEIGHT - 1);
  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(WIDTH - 1);

  logic at_first;
  logic at_last;

  assign at_first = (cur.ch == '0) && (cur.row == '0) && (cur.col == '0);
  assign at_last  = (cur.ch == LAST_CH) && (cur.row == LAST_ROW) && (cur.col == LAST_COL);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a latch.
    nxt   = cur;
    moved = 1'b0;
    case (op)
      OP_NEXT: begin
        if (!at_last) begin
          moved = 1'b1;
          if (cur.col != LAST_COL) begin
            nxt.col = cur.col + 1'b1;
          end else begin
            nxt.col = '0;
            if (cur.row != LAST_ROW) begin
              nxt.row = cur.row + 1'b1;
            end else begin
              nxt.row = '0;
              nxt.ch  = cur.ch + 1'b1;
            end
          end
        end else if (WRAP) begin
          nxt   = '0;
          moved = 1'b1;
        end
      end
      OP_PREV: begin
        if (!at_first) begin
          moved = 1'b1;
          if (cur.col != '0) begin
            nxt.col = cur.col - 1'b1;
          end else begin
            nxt.col = LAST_COL;
            if (cur.row != '0) begin
              nxt.row = cur.row - 1'b1;
            end else begin
              nxt.row = LAST_ROW;
              nxt.ch  = cur.ch - 1'b1;
            end
          end
        end else if (WRAP) begin
          nxt.ch  = LAST_CH;
          nxt.row = LAST_ROW;
          nxt.col = LAST_COL;
          moved   = 1'b1;
        end
      end
      OP_CH_NEXT: begin
        if (cur.ch != LAST_CH) begin
          nxt.ch = cur.ch + 1'b1;
          moved  = 1'b1;
        end else if (WRAP) begin
          nxt.ch = '0;
          moved  = 1'b1;
        end
      end
      OP_CH_PREV: begin
        if (cur.ch != '0) begin
          nxt.ch = cur.ch - 1'b1;
          moved  = 1'b1;
        end else if (WRAP) begin
          nxt.ch = LAST_CH;
          moved  = 1'b1;
        end
      end
      default: begin
        nxt   = cur;
        moved = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/feature_map_browser.sv
// Feature-map cursor navigator: steps (ch,row,col), fetches each new element from RAM
// and latches it for display. Define FEATURE_MAP_BROWSER_WRAP_EN for wrapping moves.
module feature_map_browser
  import feature_map_pkg::*;
#(
  parameter  int unsigned CHANNELS    = 4,
  parameter  int unsigned HEIGHT      = 4,
  parameter  int unsigned WIDTH       = 4,
  parameter  int unsigned DATA_W      = 8,
  parameter  int unsigned RD_LAT      = 1,
  parameter  int unsigned AUTO_PERIOD = 60000000,
  localparam int unsigned ADDR_W      = clog2_min1(CHANNELS * HEIGHT * WIDTH),
  localparam int unsigned CH_W        = clog2_min1(CHANNELS),
  localparam int unsigned ROW_W       = clog2_min1(HEIGHT),
  localparam int unsigned COL_W       = clog2_min1(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_next,
  input  logic              step_prev,
  input  logic              chan_next,
  input  logic              chan_prev,
  input  logic              auto_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [CH_W-1:0]   ch_idx,
  output logic [ROW_W-1:0]  row_idx,
  output logic [COL_W-1:0]  col_idx,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              busy
);

  localparam int unsigned TMR_W  = clog2_min1(AUTO_PERIOD);
  localparam int unsigned WAIT_W = clog2_min1(RD_LAT);

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [WAIT_W-1:0] wait_cnt;

  cursor_t  cur;
  cursor_t  nxt;
  move_op_t op;
  logic     moved;
  logic     manual_req;
  logic     auto_tick;

  assign cur = '{ch: IDX_W'(ch_idx), row: IDX_W'(row_idx), col: IDX_W'(col_idx)};

  assign manual_req = step_next | step_prev | chan_next | chan_prev;
  assign auto_tick  = auto_en && (timer == TMR_W'(AUTO_PERIOD - 1));

  // A single channel request outranks any step request; conflicting pairs cancel.
  always_comb begin
    op = OP_NONE;
    if (chan_next ^ chan_prev) begin
      op = chan_next ? OP_CH_NEXT : OP_CH_PREV;
    end else if (step_next ^ step_prev) begin
      op = step_next ? OP_NEXT : OP_PREV;
    end else if (auto_tick && !manual_req) begin
      op = OP_NEXT;
    end
  end

  mixed_radix_counter #(
    .CHANNELS (CHANNELS),
    .HEIGHT   (HEIGHT),
    .WIDTH    (WIDTH)
  ) u_counter (
    .cur   (cur),
    .op    (op),
    .nxt   (nxt),
    .moved (moved)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      ch_idx     <= '0;
      row_idx    <= '0;
      col_idx    <= '0;
      rd_addr    <= '0;
      rd_en      <= 1'b0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
      busy       <= 1'b0;
      timer      <= '0;
      wait_cnt   <= '0;
    end else begin
      // NOTE: all state updates use non-blocking assignments so the case below sees
      // this cycle's values regardless of statement order.
      if (!auto_en || (state == IDLE && (manual_req || auto_tick))) begin
        timer <= '0;
      end else if (state == IDLE) begin
        timer <= timer + 1'b1;
      end

      case (state)
        IDLE: begin
          if (moved) begin
            ch_idx     <= nxt.ch[CH_W-1:0];
            row_idx    <= nxt.row[ROW_W-1:0];
            col_idx    <= nxt.col[COL_W-1:0];
            rd_addr    <= ADDR_W'(flat_addr(nxt, HEIGHT, WIDTH));
            disp_valid <= 1'b0;
            rd_en      <= 1'b1;
            busy       <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: begin
          // Entered from a move the strobe is already up; entered from reset it rises here.
          busy <= 1'b1;
          if (rd_en) begin
            rd_en    <= 1'b0;
            wait_cnt <= '0;
            state    <= WAIT;
          end else begin
            rd_en <= 1'b1;
          end
        end
        WAIT: begin
          if (wait_cnt == WAIT_W'(RD_LAT - 1)) begin
            disp_data  <= rd_data;
            disp_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          rd_en <= 1'b0;
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_feature_map_browser.sv
// Self-checking bench for feature_map_browser: directed steps plus random move pulses
// checked against a linear-index reference model and a latency-accurate RAM model.
module tb_feature_map_browser;

  localparam int C      = 4;
  localparam int H      = 4;
  localparam int W      = 4;
  localparam int RD_LAT = 3;
  localparam int AP     = 8;
  localparam int PLANE  = H * W;
  localparam int N      = C * H * W;
  localparam int AW     = 6;

`ifdef FEATURE_MAP_BROWSER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          step_next = 1'b0;
  logic          step_prev = 1'b0;
  logic          chan_next = 1'b0;
  logic          chan_prev = 1'b0;
  logic          auto_en = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [1:0]    ch_idx;
  logic [1:0]    row_idx;
  logic [1:0]    col_idx;
  logic [7:0]    disp_data;
  logic          disp_valid;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int lin    = 0;
  int rd_cnt = 0;

  feature_map_browser #(
    .CHANNELS    (C),
    .HEIGHT      (H),
    .WIDTH       (W),
    .DATA_W      (8),
    .RD_LAT      (RD_LAT),
    .AUTO_PERIOD (AP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .step_next  (step_next),
    .step_prev  (step_prev),
    .chan_next  (chan_next),
    .chan_prev  (chan_prev),
    .auto_en    (auto_en),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .ch_idx     (ch_idx),
    .row_idx    (row_idx),
    .col_idx    (col_idx),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // RAM model: word = addr + 0x10 exactly RD_LAT cycles after the strobe, noise otherwise.
  logic          pipe_v [RD_LAT];
  logic [AW-1:0] pipe_a [RD_LAT];
  logic [7:0]    noise = 8'h5a;

  initial begin
    for (int i = 0; i < RD_LAT; i++) begin
      pipe_v[i] = 1'b0;
      pipe_a[i] = '0;
    end
  end

  always @(posedge clk) begin
    pipe_v[0] <= rd_en;
    pipe_a[0] <= rd_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_a[i] <= pipe_a[i-1];
    end
    noise <= 8'($urandom);
    if (rd_en === 1'b1) rd_cnt <= rd_cnt + 1;
  end

  assign rd_data = pipe_v[RD_LAT-1] ? 8'(pipe_a[RD_LAT-1]) + 8'h10 : noise;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model on the flat element index.
  function automatic void model_move(input logic sn, input logic sp, input logic cn,
                                     input logic cp, input int cur, output int nxt,
                                     output bit mv);
    int ch;
    ch  = cur / PLANE;
    nxt = cur;
    mv  = 1'b0;
    if (cn != cp) begin
      if (cn) begin
        if (ch < C - 1) begin nxt = cur + PLANE; mv = 1'b1; end
        else if (WRAP) begin nxt = cur - (C - 1) * PLANE; mv = 1'b1; end
      end else begin
        if (ch > 0) begin nxt = cur - PLANE; mv = 1'b1; end
        else if (WRAP) begin nxt = cur + (C - 1) * PLANE; mv = 1'b1; end
      end
    end else if (sn != sp) begin
      if (sn) begin
        if (cur < N - 1) begin nxt = cur + 1; mv = 1'b1; end
        else if (WRAP) begin nxt = 0; mv = 1'b1; end
      end else begin
        if (cur > 0) begin nxt = cur - 1; mv = 1'b1; end
        else if (WRAP) begin nxt = N - 1; mv = 1'b1; end
      end
    end
  endfunction

  task automatic check_cursor(input string tag, input int e);
    check({tag, " ch"}, ch_idx, e / PLANE);
    check({tag, " row"}, row_idx, (e % PLANE) / W);
    check({tag, " col"}, col_idx, e % W);
    check({tag, " rd_addr"}, rd_addr, e);
  endtask

  // Starts at posedge+1 of some cycle s; expects disp_valid in cycle s+exp_n.
  task automatic wait_done(input string tag, input int exp_n, input int e);
    int n = 0;
    @(negedge clk);
    while (disp_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
      @(negedge clk);
    end
    check({tag, " latency"}, n, exp_n);
    check({tag, " disp_data"}, disp_data, (e + 16) % 256);
    check({tag, " busy idle"}, busy, 0);
    tick();
  endtask

  // Starts and ends at posedge+1 with the DUT idle.
  task automatic do_move(input string tag, input logic sn, input logic sp, input logic cn,
                         input logic cp);
    int nl;
    bit mv;
    model_move(sn, sp, cn, cp, lin, nl, mv);
    step_next = sn; step_prev = sp; chan_next = cn; chan_prev = cp;
    tick();
    step_next = 0; step_prev = 0; chan_next = 0; chan_prev = 0;
    @(negedge clk);
    check({tag, " rd_en"}, rd_en, mv);
    check_cursor(tag, nl);
    if (mv) begin
      check({tag, " valid cleared"}, disp_valid, 0);
      check({tag, " busy"}, busy, 1);
      lin = nl;
      tick();
      wait_done(tag, RD_LAT, nl);
    end else begin
      check({tag, " valid kept"}, disp_valid, 1);
      tick();
    end
  endtask

  task automatic goto_elem(input int target);
    int guard = 0;
    while (lin != target && guard < 200) begin
      guard++;
      if (lin / PLANE < target / PLANE)      do_move("goto", 0, 0, 1, 0);
      else if (lin / PLANE > target / PLANE) do_move("goto", 0, 0, 0, 1);
      else if (lin < target)                 do_move("goto", 1, 0, 0, 0);
      else                                   do_move("goto", 0, 1, 0, 0);
    end
    check("goto reached", lin, target);
  endtask

  initial begin
    int nl;
    int n;
    int exp_gap;
    int base;
    bit mv;

    // Reset state.
    tick();
    tick();
    @(negedge clk);
    check("rst rd_en", rd_en, 0);
    check("rst busy", busy, 0);
    check("rst disp_valid", disp_valid, 0);
    check("rst disp_data", disp_data, 0);
    check_cursor("rst", 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("cycle0 rd_en", rd_en, 0);
    tick();
    @(negedge clk);
    check("cycle1 rd_en", rd_en, 1);
    check("cycle1 rd_addr", rd_addr, 0);
    check("cycle1 busy", busy, 1);
    tick();
    wait_done("first fetch", RD_LAT, 0);

    // Boundary at (0,0,0), then row carry and borrow.
    do_move("prev at origin", 0, 1, 0, 0);
    goto_elem(3);
    do_move("carry", 1, 0, 0, 0);
    check("carry addr", rd_addr, 4);
    do_move("borrow", 0, 1, 0, 0);
    check("borrow addr", rd_addr, 3);

    // End of map.
    goto_elem(N - 1);
    do_move("next at last", 1, 0, 0, 0);
    goto_elem(N - 1);
    do_move("chan_next at last ch", 0, 0, 1, 0);

    // Channel priority over step, and cancelling pairs.
    goto_elem(1 * PLANE + 2 * W + 2);
    base = rd_cnt;
    do_move("chan+step", 1, 0, 1, 0);
    check("chan+step addr", rd_addr, 42);
    tick();
    tick();
    check("chan+step one fetch", rd_cnt - base, 1);
    do_move("step both", 1, 1, 0, 0);
    do_move("chan both + step", 1, 0, 1, 1);

    // Random move pulses.
    for (int i = 0; i < 30; i++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      do_move("random", r[0], r[1], r[2], r[3]);
    end

    // Step pulse while busy is dropped.
    goto_elem(20);
    base = rd_cnt;
    model_move(1, 0, 0, 0, lin, nl, mv);
    step_next = 1'b1;
    tick();
    step_next = 1'b0;
    tick();
    step_next = 1'b1;
    @(negedge clk);
    check("busy during fetch", busy, 1);
    tick();
    step_next = 1'b0;
    wait_done("busy drop", RD_LAT - 1, nl);
    lin = nl;
    tick();
    tick();
    @(negedge clk);
    check_cursor("busy drop", nl);
    check("busy drop fetches", rd_cnt - base, 1);
    tick();

    // Auto-scan into the end of the map.
    goto_elem(N - 3);
    auto_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      model_move(1, 0, 0, 0, lin, nl, mv);
      exp_gap = (k == 0) ? AP : AP + 1 + RD_LAT;
      n = 0;
      do begin
        tick();
        n++;
        @(negedge clk);
      end while (rd_en !== 1'b1 && n < 3 * exp_gap);
      if (mv) begin
        check("auto gap", n, exp_gap);
        check("auto addr", rd_addr, nl);
        lin = nl;
      end else begin
        check("auto stall rd_en", rd_en, 0);
      end
    end
    tick();
    auto_en = 1'b0;
    n = 0;
    @(negedge clk);
    while (disp_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
      @(negedge clk);
    end
    check("auto final data", disp_data, (lin + 16) % 256);
    check_cursor("auto final", lin);
    tick();

    // Reset while waiting on the RAM.
    goto_elem(37);
    step_next = 1'b1;
    tick();
    step_next = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid rst disp_valid", disp_valid, 0);
    check("mid rst disp_data", disp_data, 0);
    check("mid rst rd_en", rd_en, 0);
    check_cursor("mid rst", 0);
    tick();
    @(negedge clk);
    check("mid rst refetch rd_en", rd_en, 1);
    check("mid rst refetch addr", rd_addr, 0);
    check("mid rst stale ignored", disp_data, 0);
    lin = 0;
    tick();
    wait_done("mid rst refetch", RD_LAT, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
